// File: rtl/conv_row_sequencer_pkg.sv
// Shared layer-control definitions for the convolution row sequencer.
package conv_row_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_LOAD = 3'd2,
        S_ACC  = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } state_e;

    localparam int unsigned D_DEFAULT  = 4;
    // Cycles allowed in ACC before the accumulate stage is declared hung.
    localparam int unsigned WDOG_LIMIT = D_DEFAULT + 3;

    function automatic int unsigned wdog_limit(input int unsigned d);
        return d + 3;
    endfunction

    // Row index width; a one-row layer still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/conv_row_sequencer.sv
// Row-level controller: conv-multiply -> accumulate -> downstream hold,
// with the next row's multiply overlapped on the output hold.
module conv_row_sequencer
    import conv_row_sequencer_pkg::*;
#(
    parameter int unsigned ROWS = 24,
    parameter int unsigned D    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,   // active-high despite the name
    input  logic                       start_i,
    output logic                       conv_start_o,
    input  logic                       conv_done_i,
    output logic                       add_load_o,
    input  logic                       add_done_i,
    output logic                       row_valid_o,
    input  logic                       row_ready_i,
    output logic [idx_width(ROWS)-1:0] row_idx_o,
    output logic                       busy_o,
    output logic                       layer_done_o,
    output logic                       err_o
);

    localparam int unsigned IDX_W = idx_width(ROWS);
    localparam int unsigned WDOG  = wdog_limit(D);
    localparam int unsigned WD_W  = $clog2(WDOG + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(WDOG - 1);

    state_e           state_q;
    logic [IDX_W-1:0] row_q;
    logic [WD_W-1:0]  wd_q;
    logic             pend_q;
    logic             conv_start_q;
    logic             add_load_q;
    logic             row_valid_q;
    logic             busy_q;
    logic             layer_done_q;
    logic             err_q;

    // Sequencer FSM; every output is a register updated on the transition.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            wd_q         <= '0;
            pend_q       <= 1'b0;
            conv_start_q <= 1'b0;
            add_load_q   <= 1'b0;
            row_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            conv_start_q <= 1'b0;
            add_load_q   <= 1'b0;
            layer_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q      <= S_CONV;
                        row_q        <= '0;
                        err_q        <= 1'b0;
                        conv_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (conv_done_i) begin
                        state_q    <= S_LOAD;
                        add_load_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    wd_q    <= '0;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    if (add_done_i) begin
                        state_q      <= S_OUT;
                        row_valid_q  <= 1'b1;
                        pend_q       <= 1'b0;
                        // Overlap the next row's multiply with this row's hold.
                        conv_start_q <= (row_q != LAST_IDX);
                    end else if (wd_q == WD_MAX) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_OUT: begin
                    // Remember an early multiply completion; repeats collapse.
                    if (conv_done_i) pend_q <= 1'b1;
                    if (row_valid_q && row_ready_i) begin
                        row_valid_q <= 1'b0;
                        pend_q      <= 1'b0;
                        if (row_q == LAST_IDX) begin
                            state_q      <= S_DONE;
                            layer_done_q <= 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                            if (pend_q || conv_done_i) begin
                                state_q    <= S_LOAD;
                                add_load_q <= 1'b1;
                            end else begin
                                state_q <= S_CONV;
                            end
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign conv_start_o = conv_start_q;
    assign add_load_o   = add_load_q;
    assign row_valid_o  = row_valid_q;
    assign row_idx_o    = row_q;
    assign busy_o       = busy_q;
    assign layer_done_o = layer_done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Scoreboard bench for conv_row_sequencer (3-row and 1-row instances).
module tb_conv_row_sequencer;

    localparam int BOUND    = 400;
    localparam int CONV_LAT = 5;
    localparam int ADD_LAT  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, cdone_a = 1'b0, cdone_m = 1'b0, adone = 1'b0, rdy = 1'b1;
    logic       cdone;
    logic       conv_start_o, add_load_o, row_valid_o, busy_o, layer_done_o, err_o;
    logic [1:0] row_idx_o;

    logic       start1 = 1'b0, cdone1 = 1'b0, adone1 = 1'b0, rdy1 = 1'b1;
    logic       conv_start1, add_load1, row_valid1, busy1, layer_done1, err1;
    logic [0:0] row_idx1;

    int n_tests = 0, n_fail = 0;
    int n_cs = 0, n_al = 0, n_ld = 0, n_cs1 = 0, n_ld1 = 0;
    bit conv_en = 1'b1, add_en = 1'b1;
    int add_row = 0;
    int exp_q[$];

    assign cdone = cdone_a | cdone_m;

    always #5 clk = ~clk;

    conv_row_sequencer #(.ROWS(3), .D(4)) u_dut (
        .clk(clk), .rst_n(rst), .start_i(start), .conv_start_o(conv_start_o),
        .conv_done_i(cdone), .add_load_o(add_load_o), .add_done_i(adone),
        .row_valid_o(row_valid_o), .row_ready_i(rdy), .row_idx_o(row_idx_o),
        .busy_o(busy_o), .layer_done_o(layer_done_o), .err_o(err_o)
    );

    conv_row_sequencer #(.ROWS(1), .D(4)) u_dut1 (
        .clk(clk), .rst_n(rst), .start_i(start1), .conv_start_o(conv_start1),
        .conv_done_i(cdone1), .add_load_o(add_load1), .add_done_i(adone1),
        .row_valid_o(row_valid1), .row_ready_i(rdy1), .row_idx_o(row_idx1),
        .busy_o(busy1), .layer_done_o(layer_done1), .err_o(err1)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor + upstream models: counts pulses, pops the scoreboard on handshakes.
    always @(negedge clk) begin
        if (!rst) begin
            if (conv_start_o) n_cs++;
            if (add_load_o)   n_al++;
            if (layer_done_o) n_ld++;
            if (conv_start1)  n_cs1++;
            if (layer_done1)  n_ld1++;
            if (row_valid_o && rdy) begin
                if (exp_q.size() == 0) check("row_unexpected", 1, 0);
                else check("row_idx", int'(row_idx_o), exp_q.pop_front());
            end
            if (conv_start_o && conv_en) fork
                begin
                    repeat (CONV_LAT) @(posedge clk);
                    #1;
                    if (conv_en) begin
                        cdone_a = 1'b1;
                        @(posedge clk); #1 cdone_a = 1'b0;
                    end
                end
            join_none
            if (add_load_o && add_en) fork
                begin
                    repeat (ADD_LAT) @(posedge clk);
                    #1;
                    if (add_en) begin
                        exp_q.push_back(add_row);
                        add_row++;
                        adone = 1'b1;
                        @(posedge clk); #1 adone = 1'b0;
                    end
                end
            join_none
        end
    end

    task automatic pulse_start();
        add_row = 0;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_ld(input string nm);
        int i = 0;
        while (!layer_done_o && i < BOUND) begin @(negedge clk); i++; end
        check(nm, int'(layer_done_o), 1);
    endtask

    task automatic wait_val(input string nm);
        int i = 0;
        while (!row_valid_o && i < BOUND) begin @(negedge clk); i++; end
        check(nm, int'(row_valid_o), 1);
    endtask

    task automatic wait_al(input string nm, input int row);
        int i = 0;
        while (!(add_load_o && int'(row_idx_o) == row) && i < BOUND) begin @(negedge clk); i++; end
        check(nm, int'(add_load_o), 1);
    endtask

    initial begin
        int b_cs, b_al, b_ld, cnt;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_conv_start", int'(conv_start_o), 0);
        check("rst_add_load",   int'(add_load_o), 0);
        check("rst_row_valid",  int'(row_valid_o), 0);
        check("rst_row_idx",    int'(row_idx_o), 0);
        check("rst_busy",       int'(busy_o), 0);
        check("rst_layer_done", int'(layer_done_o), 0);
        check("rst_err",        int'(err_o), 0);
        rst = 1'b0;
        @(negedge clk);

        // Normal 3-row layer, ready tied high
        b_cs = n_cs; b_al = n_al; b_ld = n_ld;
        pulse_start();
        check("t1_busy_after_start", int'(busy_o), 1);
        check("t1_conv_start_lat", int'(conv_start_o), 1);
        wait_ld("t1_layer_done_seen");
        check("t1_busy_in_done", int'(busy_o), 1);
        @(negedge clk);
        check("t1_busy_after_done", int'(busy_o), 0);
        check("t1_add_loads", n_al - b_al, 3);
        check("t1_conv_starts", n_cs - b_cs, 3);
        check("t1_layer_dones", n_ld - b_ld, 1);
        check("t1_err", int'(err_o), 0);
        repeat (10) @(negedge clk);

        // Downstream stall on row 0 with row 1 multiply finishing inside it
        b_cs = n_cs;
        rdy = 1'b0;
        pulse_start();
        wait_val("t2_valid_seen");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (row_valid_o) cnt++;
            @(negedge clk);
        end
        check("t2_valid_held", cnt, 20);
        check("t2_pend_set", int'(u_dut.pend_q), 1);
        rdy = 1'b1;
        @(negedge clk);
        check("t2_load_after_hs", int'(add_load_o), 1);
        check("t2_valid_dropped", int'(row_valid_o), 0);
        wait_ld("t2_layer_done_seen");
        check("t2_conv_starts", n_cs - b_cs, 3);
        repeat (10) @(negedge clk);

        // conv_done coincident with the handshake goes straight to LOAD
        conv_en = 1'b0;
        rdy = 1'b0;
        pulse_start();
        repeat (3) @(negedge clk);
        cdone_m = 1'b1;
        @(negedge clk) cdone_m = 1'b0;
        wait_val("t3_valid_seen");
        repeat (10) @(negedge clk);
        check("t3_pend_clear", int'(u_dut.pend_q), 0);
        rdy = 1'b1; cdone_m = 1'b1;
        @(posedge clk); #1 cdone_m = 1'b0;
        conv_en = 1'b1;
        @(negedge clk);
        check("t3_load_same_cycle", int'(add_load_o), 1);
        check("t3_row_idx", int'(row_idx_o), 1);
        wait_ld("t3_layer_done_seen");
        repeat (10) @(negedge clk);

        // Watchdog: accumulate never finishes
        add_en = 1'b0;
        b_ld = n_ld;
        pulse_start();
        wait_al("t4_load_seen", 0);
        repeat (7) @(negedge clk);
        check("t4_err_not_yet", int'(err_o), 0);
        @(negedge clk);
        check("t4_err_set", int'(err_o), 1);
        check("t4_idle", int'(busy_o), 0);
        repeat (5) @(negedge clk);
        check("t4_no_layer_done", n_ld - b_ld, 0);
        check("t4_err_sticky", int'(err_o), 1);
        add_en = 1'b1;
        pulse_start();
        check("t4_err_cleared", int'(err_o), 0);
        wait_ld("t4_layer_done_after_restart");
        repeat (10) @(negedge clk);

        // Reset during row 1 accumulate, with spurious start/conv_done
        pulse_start();
        wait_al("t5_row1_load_seen", 1);
        @(negedge clk);
        add_en = 1'b0; conv_en = 1'b0;
        rst = 1'b1; start = 1'b1; cdone_m = 1'b1;
        @(negedge clk);
        check("t5_busy", int'(busy_o), 0);
        check("t5_row_idx", int'(row_idx_o), 0);
        check("t5_valid", int'(row_valid_o), 0);
        check("t5_conv_start", int'(conv_start_o) | int'(add_load_o) | int'(layer_done_o) | int'(err_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0; cdone_m = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_stays_idle", int'(busy_o), 0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        add_en = 1'b1; conv_en = 1'b1;

        // Single-row layer on the ROWS=1 instance
        b_cs = n_cs1; b_ld = n_ld1;
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        check("t6_conv_start", int'(conv_start1), 1);
        repeat (3) @(negedge clk);
        cdone1 = 1'b1;
        @(negedge clk) cdone1 = 1'b0;
        check("t6_add_load", int'(add_load1), 1);
        repeat (2) @(negedge clk);
        adone1 = 1'b1;
        @(negedge clk) adone1 = 1'b0;
        check("t6_row_valid", int'(row_valid1), 1);
        check("t6_row_idx", int'(row_idx1), 0);
        check("t6_no_2nd_conv_start", int'(conv_start1), 0);
        @(negedge clk);
        check("t6_layer_done", int'(layer_done1), 1);
        repeat (5) @(negedge clk);
        check("t6_conv_starts", n_cs1 - b_cs, 1);
        check("t6_layer_dones", n_ld1 - b_ld, 1);
        check("t6_idle", int'(busy1), 0);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
